// File: rtl/iob_uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings and guard counter width.
package iob_uart_tx_arb_pkg;

   localparam int unsigned GuardCntW = 4;

   localparam logic [1:0] StIdleEnc   = 2'd0;
   localparam logic [1:0] StWaitTxEnc = 2'd1;
   localparam logic [1:0] StWriteEnc  = 2'd2;
   localparam logic [1:0] StGuardEnc  = 2'd3;

   typedef enum logic [1:0] {
      StIdle   = StIdleEnc,
      StWaitTx = StWaitTxEnc,
      StWrite  = StWriteEnc,
      StGuard  = StGuardEnc
   } arb_state_e;

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i (wrapping), one-hot out.
module iob_rr_pick #(
   parameter int unsigned N    = 4,
   parameter int unsigned PtrW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [PtrW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o
);

   logic            found;
   logic [PtrW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PtrW'((int'(ptr_i) + i) % N);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iob_uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding bytes from N_REQ requesters into uart_core,
// with a post-write guard window during which the transmitter-idle flag is ignored.
module iob_uart_tx_arb
   import iob_uart_tx_arb_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned GUARD  = 2
) (
   input  logic                    clk_i,
   input  logic                    arst_n_i,
   input  logic                    soft_rst_i,
   input  logic                    en_i,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   input  logic [N_REQ-1:0]        req_last_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic                    tx_ready_i,
   output logic [DATA_W-1:0]       tx_data_o,
   output logic                    tx_write_en_o,
   output logic [N_REQ-1:0]        grant_o,
   output logic                    busy_o
);

   localparam int unsigned PtrW = $clog2(N_REQ);

   arb_state_e            state_q, state_d;
   logic [N_REQ-1:0]      grant_q, grant_d;
   logic [PtrW-1:0]       last_owner_q, last_owner_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  last_q, last_d;
   logic [GuardCntW-1:0]  guard_cnt_q, guard_cnt_d;

   logic [PtrW-1:0]       own_idx;
   logic                  own_valid;
   logic                  own_last;
   logic [DATA_W-1:0]     own_data;
   logic [PtrW-1:0]       rr_ptr;
   logic [N_REQ-1:0]      pick;

   // Owner-side mux driven by the one-hot grant register.
   always_comb begin
      own_idx   = '0;
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_q[k]) begin
            own_idx   = PtrW'(k);
            own_valid = req_valid_i[k];
            own_last  = req_last_i[k];
            own_data  = req_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign rr_ptr = (last_owner_q == PtrW'(N_REQ - 1)) ? '0 : last_owner_q + 1'b1;

   iob_rr_pick #(
      .N    (N_REQ),
      .PtrW (PtrW)
   ) u_rr_pick (
      .req_i (req_valid_i),
      .ptr_i (rr_ptr),
      .gnt_o (pick)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_owner_d = last_owner_q;
      data_d       = data_q;
      last_d       = last_q;
      guard_cnt_d  = guard_cnt_q;
      req_ready_o  = '0;

      unique case (state_q)
         StIdle: begin
            if (en_i && (|req_valid_i)) begin
               grant_d = pick;
               state_d = StWaitTx;
            end
         end
         StWaitTx: begin
            req_ready_o = grant_q & {N_REQ{own_valid & tx_ready_i}};
            if (own_valid && tx_ready_i) begin
               data_d  = own_data;
               last_d  = own_last;
               state_d = StWrite;
            end
         end
         StWrite: begin
            guard_cnt_d = '0;
            state_d     = StGuard;
         end
         StGuard: begin
            if (guard_cnt_q == GuardCntW'(GUARD - 1)) begin
               guard_cnt_d = '0;
               if (last_q) begin
                  last_owner_d = own_idx;
                  grant_d      = '0;
                  state_d      = StIdle;
               end else begin
                  state_d = StWaitTx;
               end
            end else begin
               guard_cnt_d = guard_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Soft reset overrides every transition, including mid-packet.
      if (soft_rst_i) begin
         state_d      = StIdle;
         grant_d      = '0;
         last_owner_d = PtrW'(N_REQ - 1);
         data_d       = '0;
         last_d       = 1'b0;
         guard_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_owner_q <= PtrW'(N_REQ - 1);
         data_q       <= '0;
         last_q       <= 1'b0;
         guard_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_owner_q <= last_owner_d;
         data_q       <= data_d;
         last_q       <= last_d;
         guard_cnt_q  <= guard_cnt_d;
      end
   end

   assign tx_write_en_o = (state_q == StWrite);
   assign busy_o        = (state_q != StIdle);
   assign grant_o       = grant_q;
   assign tx_data_o     = data_q;

endmodule

// File: tb/tb_iob_uart_tx_arb.sv
// Randomised and directed bench for iob_uart_tx_arb against a transaction-level reference model.
module tb_iob_uart_tx_arb;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int G  = 2;

   logic            clk_i = 1'b0;
   logic            arst_n_i;
   logic            soft_rst_i;
   logic            en_i;
   logic [N-1:0]    req_valid_i;
   logic [N*DW-1:0] req_data_i;
   logic [N-1:0]    req_last_i;
   logic [N-1:0]    req_ready_o;
   logic            tx_ready_i;
   logic [DW-1:0]   tx_data_o;
   logic            tx_write_en_o;
   logic [N-1:0]    grant_o;
   logic            busy_o;

   always #5 clk_i = ~clk_i;

   iob_uart_tx_arb #(
      .N_REQ  (N),
      .DATA_W (DW),
      .GUARD  (G)
   ) dut (
      .clk_i         (clk_i),
      .arst_n_i      (arst_n_i),
      .soft_rst_i    (soft_rst_i),
      .en_i          (en_i),
      .req_valid_i   (req_valid_i),
      .req_data_i    (req_data_i),
      .req_last_i    (req_last_i),
      .req_ready_o   (req_ready_o),
      .tx_ready_i    (tx_ready_i),
      .tx_data_o     (tx_data_o),
      .tx_write_en_o (tx_write_en_o),
      .grant_o       (grant_o),
      .busy_o        (busy_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Requester packet queues: {last, byte}; present[k] gates whether k shows valid this cycle.
   logic [8:0]   pq [N][$];
   logic [N-1:0] present;

   // Reference model: owner (-1 = none), pending write, remaining guard cycles.
   int          m_owner;
   int          m_guard;
   int          m_last_owner;
   bit          m_wr;
   bit          m_last;
   logic [7:0]  m_data;

   int          log_own [$];
   logic [7:0]  log_dat [$];
   int          log_cyc [$];
   int          cyc_n = 0;

   task automatic model_reset();
      m_owner      = -1;
      m_guard      = 0;
      m_wr         = 0;
      m_last       = 0;
      m_data       = '0;
      m_last_owner = N - 1;
   endtask

   task automatic model_edge();
      int o;
      if (soft_rst_i) begin
         model_reset();
      end else if (m_wr) begin
         m_wr    = 0;
         m_guard = G;
      end else if (m_guard > 0) begin
         m_guard--;
         if (m_guard == 0 && m_last) begin
            m_last_owner = m_owner;
            m_owner      = -1;
         end
      end else if (m_owner >= 0) begin
         o = m_owner;
         if (req_valid_i[o] && tx_ready_i) begin
            m_wr   = 1;
            m_data = pq[o][0][7:0];
            m_last = pq[o][0][8];
            void'(pq[o].pop_front());
         end
      end else if (en_i) begin
         for (int i = 1; i <= N; i++) begin
            o = (m_last_owner + i) % N;
            if (m_owner < 0 && req_valid_i[o]) m_owner = o;
         end
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         if (pq[k].size() > 0) begin
            req_valid_i[k]              = present[k];
            req_data_i[k*DW +: DW]      = pq[k][0][7:0];
            req_last_i[k]               = pq[k][0][8];
         end else begin
            req_valid_i[k]              = 1'b0;
            req_data_i[k*DW +: DW]      = 8'($urandom);
            req_last_i[k]               = 1'b0;
         end
      end
   endtask

   // One clock: apply inputs, compare at negedge, advance the model at posedge.
   task automatic cycle();
      logic [N-1:0] eg, er;
      int gi;
      drive();
      @(negedge clk_i);
      eg = '0;
      er = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      if (m_owner >= 0 && !m_wr && m_guard == 0)
         er[m_owner] = req_valid_i[m_owner] & tx_ready_i;
      check("grant", grant_o, eg);
      check("busy", busy_o, m_owner >= 0);
      check("ready", req_ready_o, er);
      check("wr_en", tx_write_en_o, m_wr);
      check("tx_data", tx_data_o, m_data);
      if (tx_write_en_o) begin
         gi = -1;
         for (int k = 0; k < N; k++) if (grant_o[k]) gi = k;
         log_own.push_back(gi);
         log_dat.push_back(tx_data_o);
         log_cyc.push_back(cyc_n);
      end
      @(posedge clk_i);
      if (arst_n_i) model_edge();
      else model_reset();
      cyc_n++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic push_pkt(input int k, input int len, input logic [7:0] base);
      for (int i = 0; i < len; i++) pq[k].push_back({(i == len - 1), base + 8'(i)});
   endtask

   task automatic clear_logs();
      log_own.delete();
      log_dat.delete();
      log_cyc.delete();
   endtask

   task automatic flush();
      for (int k = 0; k < N; k++) pq[k].delete();
      present    = '1;
      en_i       = 1'b1;
      tx_ready_i = 1'b1;
      soft_rst_i = 1'b1;
      cycle();
      soft_rst_i = 1'b0;
      clear_logs();
   endtask

   task automatic check_owners(input string tag, input int exp_own[$]);
      check({tag, "_count"}, log_own.size(), exp_own.size());
      for (int i = 0; i < exp_own.size(); i++)
         check(tag, (i < log_own.size()) ? log_own[i] : -1, exp_own[i]);
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_grant"}, grant_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_wr_en"}, tx_write_en_o, 0);
      check({tag, "_data"}, tx_data_o, 0);
      check({tag, "_ready"}, req_ready_o, 0);
   endtask

   initial begin
      arst_n_i    = 1'b0;
      soft_rst_i  = 1'b0;
      en_i        = 1'b0;
      tx_ready_i  = 1'b0;
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      present     = '1;
      model_reset();
      #12;
      check_outputs_reset("por");
      @(posedge clk_i);
      #1 arst_n_i = 1'b1;

      // Three-byte packet from requester 0, strobes spaced by WAIT_TX + WRITE + GUARD.
      flush();
      push_pkt(0, 3, 8'h41);
      run(16);
      check_owners("t1_owner", '{0, 0, 0});
      for (int i = 0; i < 3; i++)
         check("t1_data", (i < log_dat.size()) ? log_dat[i] : 8'h00, 8'h41 + 8'(i));
      if (log_cyc.size() == 3) begin
         check("t1_gap0", log_cyc[1] - log_cyc[0], 2 + G);
         check("t1_gap1", log_cyc[2] - log_cyc[1], 2 + G);
      end
      check("t1_idle_grant", grant_o, 0);

      // Four single-byte requesters, requester 0 twice: strict rotation.
      flush();
      for (int k = 0; k < N; k++) push_pkt(k, 1, 8'h10 + 8'(k));
      push_pkt(0, 1, 8'h1f);
      run(40);
      check_owners("t2_owner", '{0, 1, 2, 3, 0});

      // Requester 2 holds the grant for its whole packet; then 3, 0, 1.
      flush();
      push_pkt(2, 3, 8'h20);
      run(2);
      push_pkt(1, 1, 8'h31);
      push_pkt(3, 1, 8'h33);
      push_pkt(0, 1, 8'h30);
      run(50);
      check_owners("t3_owner", '{2, 2, 2, 3, 0, 1});

      // Transmitter busy for 20 cycles in WAIT_TX, then accept and strobe.
      flush();
      tx_ready_i = 1'b0;
      push_pkt(1, 1, 8'h55);
      run(22);
      check("t4_no_strobe", log_own.size(), 0);
      tx_ready_i = 1'b1;
      cycle();
      check("t4_accept_no_strobe_yet", log_own.size(), 0);
      cycle();
      check("t4_strobe", log_own.size(), 1);
      check("t4_data", (log_dat.size() > 0) ? log_dat[0] : 8'h00, 8'h55);

      // Enable drops mid-packet: packet finishes, no new grant until re-enabled.
      flush();
      push_pkt(0, 3, 8'h60);
      push_pkt(1, 1, 8'h70);
      run(2);
      en_i = 1'b0;
      run(30);
      check_owners("t5_owner", '{0, 0, 0});
      check("t5_no_grant", grant_o, 0);
      en_i = 1'b1;
      run(10);
      check("t5_resume", (log_own.size() == 4) ? log_own[3] : -1, 1);

      // Soft reset in GUARD, then async reset in WRITE; next grant goes to requester 0.
      flush();
      push_pkt(3, 2, 8'h80);
      for (int i = 0; i < 20 && m_guard == 0; i++) cycle();
      check("t6_reach_guard", m_guard > 0, 1);
      for (int k = 0; k < N; k++) pq[k].delete();
      soft_rst_i = 1'b1;
      cycle();
      soft_rst_i = 1'b0;
      check_outputs_reset("t6_soft");
      push_pkt(2, 2, 8'h90);
      for (int i = 0; i < 20 && !m_wr; i++) cycle();
      check("t6_reach_write", m_wr, 1);
      #2 arst_n_i = 1'b0;
      #1 check_outputs_reset("t6_arst");
      model_reset();
      for (int k = 0; k < N; k++) pq[k].delete();
      push_pkt(2, 1, 8'ha0);
      push_pkt(0, 1, 8'hb0);
      clear_logs();
      @(posedge clk_i);
      #1 arst_n_i = 1'b1;
      run(12);
      check("t6_first_owner", (log_own.size() > 0) ? log_own[0] : -1, 0);

      // Random traffic: packet refills, valid gaps, ready/enable noise, occasional soft reset.
      flush();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            if (pq[k].size() == 0 && $urandom_range(3) == 0)
               push_pkt(k, $urandom_range(1, 3), 8'($urandom));
            present[k] = ($urandom_range(5) != 0);
         end
         tx_ready_i = ($urandom_range(3) != 0);
         en_i       = ($urandom_range(9) != 0);
         soft_rst_i = ($urandom_range(149) == 0);
         cycle();
      end
      soft_rst_i = 1'b0;
      check("rand_activity", log_own.size() > 50, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/iob_uart_tx_arb.md
IOB_UART_TX_ARB -- requirements
Module: iob_uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DATA_W, default 8, SHALL set the byte width toward uart_core.
REQ-003 Parameter GUARD, default 2, SHALL set the post-write cycles during which tx_ready_i is ignored (1..15).
REQ-004 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 arst_n_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 soft_rst_i  in  1  SHALL be a synchronous, active-high soft reset.
REQ-007 en_i  in  1  SHALL enable new grants.
REQ-008 req_valid_i  in  N_REQ  SHALL be the per-requester byte-valid flags.
REQ-009 req_data_i  in  N_REQ*DATA_W  SHALL carry the bytes; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-010 req_last_i  in  N_REQ  SHALL mark the final byte of a requester's packet.
REQ-011 req_ready_o  out  N_REQ  SHALL be the per-requester accept strobes.
REQ-012 tx_ready_i  in  1  SHALL be the uart_core transmitter-idle flag.
REQ-013 tx_data_o  out  DATA_W  SHALL be the byte presented to uart_core.
REQ-014 tx_write_en_o  out  1  SHALL be a one-cycle write strobe to uart_core.
REQ-015 grant_o  out  N_REQ  SHALL be the one-hot current owner; all-zero when no owner.
REQ-016 busy_o  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_TX, WRITE and GUARD.
REQ-018 IDLE exit: with en_i=1 and any req_valid_i bit set, the FSM SHALL select the winner by round-robin, register it in grant_o, and enter WAIT_TX on the next cycle.
REQ-019 Round-robin search SHALL start at index (last_owner+1) mod N_REQ; last_owner resets to N_REQ-1, so requester 0 has first priority.
REQ-020 In WAIT_TX, req_ready_o[g] SHALL equal req_valid_i[g] & tx_ready_i (combinational) for owner g; all other req_ready_o bits SHALL be 0 in every state.
REQ-021 On acceptance (valid & ready), the byte and req_last_i[g] SHALL be registered, and the FSM SHALL enter WRITE.
REQ-022 In WRITE, tx_write_en_o SHALL be 1 for exactly one cycle; tx_data_o SHALL hold the accepted byte from WRITE until the next acceptance.
REQ-023 Latency from acceptance to tx_write_en_o SHALL be exactly one cycle.
REQ-024 GUARD SHALL last exactly GUARD cycles, ignoring tx_ready_i; its counter SHALL be 4 bits and SHALL not wrap.
REQ-025 GUARD exit: if the registered last flag is 1, the FSM SHALL enter IDLE, set last_owner=g and clear grant_o; otherwise it SHALL enter WAIT_TX with the grant kept.
REQ-026 The grant SHALL stay locked until the last byte; if the owner drops valid mid-packet, the FSM SHALL wait in WAIT_TX indefinitely.
REQ-027 en_i=0 SHALL block only the IDLE exit; a packet in progress SHALL complete.
REQ-028 Valid from non-owners SHALL be ignored until the owner's packet ends.
REQ-029 When a single requester is valid, it SHALL win regardless of pointer position.

Reset
REQ-030 arst_n_i low SHALL immediately force IDLE, grant_o=0, tx_data_o=0, tx_write_en_o=0, req_ready_o=0, busy_o=0, last_owner=N_REQ-1 and the guard counter to 0.
REQ-031 soft_rst_i=1 SHALL apply the same values on the next edge from any state, including mid-packet, and SHALL take priority over all other transitions.
REQ-032 A write strobe already issued before reset SHALL NOT be repeated or retracted.

Structure
REQ-033 State encodings and the GUARD counter width SHALL be localparams in the shared iob_uart package header.
REQ-034 Round-robin selection SHALL be one combinational sub-module, iob_rr_pick (request vector plus pointer in, one-hot out).
REQ-035 The block SHALL sit between the software register file / DMA requesters and uart_core, driving its tx_data_i and data_write_en_i ports.

Verification
REQ-036 Requester 0 sends a 3-byte packet 0x41, 0x42, 0x43 (last on 0x43) with tx_ready_i=1 -> three strobes, 4 cycles apart (WAIT_TX+WRITE+GUARD=2), tx_data_o in order, then IDLE and grant_o=0.
REQ-037 All four requesters valid, each sending single-byte packets -> grant order 0, 1, 2, 3, 0.
REQ-038 Requester 2 is mid-packet and requester 1 asserts valid -> requester 1 is not granted until requester 2's last byte, then requester 3 and requester 0 are checked before 1.
REQ-039 tx_ready_i held 0 for 20 cycles in WAIT_TX -> req_ready_o stays 0 and there is no strobe; tx_ready_i rises -> acceptance the same cycle, strobe the next.
REQ-040 en_i falls mid-packet -> the packet completes, then no new grant while en_i=0.
REQ-041 soft_rst_i pulsed during GUARD, then arst_n_i pulsed during WRITE -> all outputs at reset values, and the next grant goes to requester 0.
